caption_sequencer: RTL and testbench

Schedules translated caption strings onto the caption overlay renderer. Accepts strings from the translation engine over a valid/ready handshake and buffers them in a small FIFO. Presents each string to the renderer's `text_valid`/`text_string`/`text_length` inputs only on a frame boundary, enforces minimum and maximum on-screen durations counted in frames, and blanks the caption by loading a zero-length string. Sits between the translation engine and the caption renderer, in the `clk` domain.

---
 rtl/caption_pkg.sv | 18 +
 rtl/caption_fifo.sv | 62 ++++++
 rtl/caption_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_caption_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caption_pkg.sv
// Shared types for the caption sequencer: queued entry layout, FSM states and the blank character.
package caption_pkg;

    localparam int         CAPTION_TEXT_BITS  = 256;
    localparam int         CAPTION_LEN_BITS   = 5;
    localparam logic [7:0] CAPTION_CLEAR_CHAR = 8'h20;

    typedef struct packed {
        logic [CAPTION_TEXT_BITS-1:0] text;
        logic [CAPTION_LEN_BITS-1:0]  length;
    } caption_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        SHOWING = 1'b1
    } seq_state_t;

endpackage

// File: rtl/caption_fifo.sv
// Synchronous FIFO of caption entries with a flush that empties it in one cycle.
module caption_fifo
    import caption_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = caption_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     wr_entry,
    input  logic                       pop,
    output entry_t                     rd_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !flush && (count < CNT_W'(DEPTH));
    assign do_pop   = pop && !flush && (count != '0);
    assign rd_entry = mem[rd_ptr];

    // Storage carries no reset; only the pointers and occupancy are control state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/caption_sequencer.sv
// Frame-aligned caption scheduler feeding the overlay renderer with min/max hold times.
// Optional duplicate suppression is built when CAPTION_QUEUE_DEDUP_EN is defined.
module caption_sequencer
    import caption_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int TEXT_BITS   = 256,
    parameter int LEN_BITS    = 5,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TEXT_BITS-1:0]             in_text,
    input  logic [LEN_BITS-1:0]              in_length,
    input  logic                             frame_start,
    input  logic                             cfg_enable,
    input  logic [FRAME_CNT_W-1:0]           cfg_min_frames,
    input  logic [FRAME_CNT_W-1:0]           cfg_max_frames,
    output logic                             out_text_valid,
    output logic [TEXT_BITS-1:0]             out_text_string,
    output logic [LEN_BITS-1:0]              out_text_length,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic                             showing,
    output logic [7:0]                       dup_count
);

    localparam int                   CNT_W      = $clog2(QUEUE_DEPTH+1);
    localparam logic [TEXT_BITS-1:0] CLEAR_TEXT = {(TEXT_BITS/8){CAPTION_CLEAR_CHAR}};

    typedef struct packed {
        logic [TEXT_BITS-1:0] text;
        logic [LEN_BITS-1:0]  length;
    } entry_t;

    function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    seq_state_t             state_q;
    seq_state_t             state_d;
    logic [FRAME_CNT_W-1:0] fcnt_q;
    logic [FRAME_CNT_W:0]   fcnt_inc;
    logic                   min_met;
    logic                   max_hit;
    logic                   pop;
    logic                   do_load;
    logic                   do_clear;
    logic                   accept;
    logic                   is_dup;
    logic                   wr_en;
    logic [CNT_W-1:0]       count_nxt;
    entry_t                 in_entry;
    entry_t                 head;

    assign in_entry = '{text: in_text, length: in_length};
    assign accept   = in_valid && in_ready && cfg_enable;
    assign wr_en    = accept && !is_dup;
    assign showing  = (state_q == SHOWING);

    // Widened so the +1 comparison cannot wrap when fcnt is saturated.
    assign fcnt_inc = {1'b0, fcnt_q} + 1'b1;
    assign min_met  = fcnt_inc >= {1'b0, cfg_min_frames};
    assign max_hit  = (cfg_max_frames != '0) && (fcnt_inc >= {1'b0, cfg_max_frames});

    caption_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (!cfg_enable),
        .push     (wr_en),
        .wr_entry (in_entry),
        .pop      (pop),
        .rd_entry (head),
        .count    (queue_count)
    );

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        do_load  = 1'b0;
        do_clear = 1'b0;
        if (!cfg_enable) begin
            state_d  = IDLE;
            do_clear = (state_q == SHOWING);
        end else if (frame_start) begin
            case (state_q)
                IDLE: begin
                    if (queue_count != '0) begin
                        pop     = 1'b1;
                        do_load = 1'b1;
                        state_d = SHOWING;
                    end
                end
                SHOWING: begin
                    if ((queue_count != '0) && min_met) begin
                        pop     = 1'b1;
                        do_load = 1'b1;
                    end else if ((queue_count == '0) && max_hit) begin
                        do_clear = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt = queue_count;
        if (wr_en && !pop) begin
            count_nxt = queue_count + 1'b1;
        end else if (!wr_en && pop) begin
            count_nxt = queue_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            fcnt_q          <= '0;
            in_ready        <= 1'b0;
            out_text_valid  <= 1'b0;
            out_text_string <= '0;
            out_text_length <= '0;
        end else begin
            state_q        <= state_d;
            in_ready       <= cfg_enable && (count_nxt < CNT_W'(QUEUE_DEPTH));
            out_text_valid <= do_load || do_clear;
            if (do_load) begin
                out_text_string <= head.text;
                out_text_length <= head.length;
            end else if (do_clear) begin
                out_text_string <= CLEAR_TEXT;
                out_text_length <= '0;
            end
            if (do_load || do_clear) begin
                fcnt_q <= '0;
            end else if (frame_start && cfg_enable) begin
                fcnt_q <= sat_inc(fcnt_q);
            end
        end
    end

`ifdef CAPTION_QUEUE_DEDUP_EN
    entry_t     ref_q;
    logic       ref_vld_q;
    logic [7:0] dup_q;

    // A clear in the same cycle invalidates the reference before the compare.
    assign is_dup    = ref_vld_q && !do_clear && (in_entry == ref_q);
    assign dup_count = dup_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ref_q <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_vld_q <= 1'b0;
            dup_q     <= '0;
        end else begin
            if (wr_en) begin
                ref_vld_q <= 1'b1;
            end else if (!cfg_enable || do_clear) begin
                ref_vld_q <= 1'b0;
            end
            if (accept && is_dup && (dup_q != 8'hFF)) begin
                dup_q <= dup_q + 8'd1;
            end
        end
    end
`else
    assign is_dup    = 1'b0;
    assign dup_count = '0;
`endif

endmodule

// File: tb/tb_caption_sequencer.sv
// Bench for caption_sequencer: directed table, hand sequences and random traffic against a queue model.
module tb_caption_sequencer;

    localparam logic [255:0] BLANK = {32{8'h20}};
    localparam logic [255:0] ZERO  = '0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_text = '0;
    logic [4:0]   in_length = '0;
    logic         frame_start = 1'b0;
    logic         cfg_enable = 1'b0;
    logic [7:0]   cfg_min_frames = 8'd2;
    logic [7:0]   cfg_max_frames = 8'd3;
    logic         out_text_valid;
    logic [255:0] out_text_string;
    logic [4:0]   out_text_length;
    logic [2:0]   queue_count;
    logic         showing;
    logic [7:0]   dup_count;

    int total = 0;
    int bad = 0;

    caption_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_text         (in_text),
        .in_length       (in_length),
        .frame_start     (frame_start),
        .cfg_enable      (cfg_enable),
        .cfg_min_frames  (cfg_min_frames),
        .cfg_max_frames  (cfg_max_frames),
        .out_text_valid  (out_text_valid),
        .out_text_string (out_text_string),
        .out_text_length (out_text_length),
        .queue_count     (queue_count),
        .showing         (showing),
        .dup_count       (dup_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int c);
        logic [255:0] t;
        t = BLANK;
        t[255:248] = 8'(c);
        return t;
    endfunction

    // Reference model: a plain queue plus "what is on screen" and frames shown.
    typedef struct packed { logic [255:0] t; logic [4:0] l; } ent_t;
    ent_t         mq[$];
    ent_t         m_in, m_hd, m_ref;
    bit           m_ready = 0, m_show = 0, m_vld = 0, m_refv = 0, m_acc = 0;
    int           m_fcnt = 0, m_dup = 0, m_c0 = 0;
    logic [255:0] m_str = '0;
    logic [4:0]   m_len = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ready = 0; m_show = 0; m_vld = 0; m_refv = 0;
                m_fcnt = 0; m_dup = 0; m_str = '0; m_len = '0;
            end else begin
                m_acc = in_valid && m_ready && cfg_enable;
                m_in  = '{in_text, in_length};
                m_vld = 0;
                if (!cfg_enable) begin
                    if (m_show) begin m_vld = 1; m_str = BLANK; m_len = 0; end
                    m_show = 0; m_fcnt = 0; m_refv = 0; m_ready = 0;
                    mq.delete();
                end else begin
                    m_c0 = mq.size();
                    if (frame_start) begin
                        if (m_c0 > 0 && (!m_show || m_fcnt + 1 >= int'(cfg_min_frames))) begin
                            m_hd = mq.pop_front();
                            m_vld = 1; m_str = m_hd.t; m_len = m_hd.l; m_show = 1; m_fcnt = 0;
                        end else if (m_show && m_c0 == 0 && cfg_max_frames != 0 &&
                                     m_fcnt + 1 >= int'(cfg_max_frames)) begin
                            m_vld = 1; m_str = BLANK; m_len = 0; m_show = 0; m_fcnt = 0; m_refv = 0;
                        end else if (m_show) begin
                            m_fcnt = (m_fcnt < 255) ? m_fcnt + 1 : 255;
                        end
                    end
                    if (m_acc) begin
`ifdef CAPTION_QUEUE_DEDUP_EN
                        if (m_refv && m_in == m_ref) begin
                            if (m_dup < 255) m_dup++;
                        end else begin
                            mq.push_back(m_in); m_ref = m_in; m_refv = 1;
                        end
`else
                        mq.push_back(m_in);
`endif
                    end
                    m_ready = mq.size() < 4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("model", 300'({out_text_valid, out_text_length, out_text_string, queue_count,
                                showing, in_ready, dup_count}),
                         300'({m_vld, m_len, m_str, 3'(mq.size()), m_show, m_ready, 8'(m_dup)}));
        end
    end

    typedef struct {
        logic         iv;
        logic [255:0] it;
        logic [4:0]   il;
        logic         fs;
        logic         ev;
        logic [4:0]   el;
        logic [255:0] es;
        logic [2:0]   ec;
        logic         esh;
    } vec_t;
    vec_t tbl[12];

    task automatic restart();
        @(negedge clk);
        in_valid = 0; frame_start = 0; cfg_enable = 0;
        repeat (2) @(negedge clk);
        cfg_enable = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic offer(input logic [255:0] t, input logic [4:0] l);
        @(negedge clk);
        in_valid = 1; in_text = t; in_length = l;
    endtask

    task automatic frame_and_wait(output bit got);
        @(negedge clk);
        in_valid = 0; frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        got = out_text_valid;
    endtask

    bit got;
    int n, at;
    logic [255:0] pick[3];

    initial begin
        logic [255:0] hello, ab;
        hello = mk(72);
        hello[247:216] = "ELLO";
        ab = mk(65);
        ab[247:240] = "B";

        tbl[0]  = '{1'b1, hello, 5'd5, 1'b0, 1'b0, 5'd0, ZERO,  3'd1, 1'b0};
        tbl[1]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b1, 5'd5, hello, 3'd0, 1'b1};
        tbl[2]  = '{1'b0, ZERO,  5'd0, 1'b0, 1'b0, 5'd5, hello, 3'd0, 1'b1};
        tbl[3]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b0, 5'd5, hello, 3'd0, 1'b1};
        tbl[4]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b0, 5'd5, hello, 3'd0, 1'b1};
        tbl[5]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b1, 5'd0, BLANK, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, ZERO,  5'd0, 1'b0, 1'b0, 5'd0, BLANK, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, ab,    5'd2, 1'b1, 1'b0, 5'd0, BLANK, 3'd1, 1'b0};
        tbl[8]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b1, 5'd2, ab,    3'd0, 1'b1};
        tbl[9]  = '{1'b0, ZERO,  5'd0, 1'b1, 1'b0, 5'd2, ab,    3'd0, 1'b1};
        tbl[10] = '{1'b0, ZERO,  5'd0, 1'b1, 1'b0, 5'd2, ab,    3'd0, 1'b1};
        tbl[11] = '{1'b0, ZERO,  5'd0, 1'b1, 1'b1, 5'd0, BLANK, 3'd0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("reset_outputs", 300'({out_text_valid, out_text_length, out_text_string, queue_count,
                                    showing, in_ready, dup_count}), 300'(0));
        cfg_enable = 1;
        repeat (2) @(negedge clk);
        chk("ready_after_enable", 300'(in_ready), 300'(1));

        // Single entry with min=2, max=3; frame coinciding with accept; back-to-back frames.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_text = tbl[i].it; in_length = tbl[i].il;
            frame_start = tbl[i].fs;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 300'(out_text_valid), 300'(tbl[i].ev));
            chk($sformatf("tbl%0d_len", i), 300'(out_text_length), 300'(tbl[i].el));
            chk($sformatf("tbl%0d_str", i), 300'(out_text_string), 300'(tbl[i].es));
            chk($sformatf("tbl%0d_count", i), 300'(queue_count), 300'(tbl[i].ec));
            chk($sformatf("tbl%0d_showing", i), 300'(showing), 300'(tbl[i].esh));
        end

        // Queue pressure: five offers, four fit; then one load per frame in order.
        restart();
        cfg_min_frames = 1; cfg_max_frames = 0;
        for (int i = 0; i < 5; i++) offer(mk(48 + i), 5'(i + 1));
        @(negedge clk);
        in_valid = 0;
        chk("full_count", 300'(queue_count), 300'(4));
        chk("full_ready", 300'(in_ready), 300'(0));
        for (int i = 0; i < 4; i++) begin
            frame_and_wait(got);
            chk($sformatf("order%0d_valid", i), 300'(got), 300'(1));
            chk($sformatf("order%0d_len", i), 300'(out_text_length), 300'(i + 1));
            chk($sformatf("order%0d_str", i), 300'(out_text_string), 300'(mk(48 + i)));
            repeat (8) @(negedge clk);
        end
        chk("drained_count", 300'(queue_count), 300'(0));

        // Minimum hold of five frames.
        restart();
        cfg_min_frames = 5; cfg_max_frames = 0;
        offer(mk(69), 5'd7);
        offer(mk(70), 5'd9);
        frame_and_wait(got);
        chk("hold_first_len", 300'(out_text_length), 300'(7));
        at = 0;
        for (int f = 1; f <= 8; f++) begin
            frame_and_wait(got);
            if (got && at == 0) at = f;
            repeat (2) @(negedge clk);
        end
        chk("hold_frames", 300'(at), 300'(5));
        chk("hold_second_len", 300'(out_text_length), 300'(9));

        // max=0: never auto-clears, even past counter saturation.
        restart();
        cfg_min_frames = 1; cfg_max_frames = 0;
        offer(mk(77), 5'd3);
        frame_and_wait(got);
        n = 0;
        for (int f = 0; f < 300; f++) begin
            frame_and_wait(got);
            n += int'(got);
        end
        chk("nomax_pulses", 300'(n), 300'(0));
        chk("nomax_showing", 300'(showing), 300'(1));

        // Disable while showing with two queued.
        cfg_min_frames = 200;
        offer(mk(80), 5'd4);
        offer(mk(81), 5'd20);
        @(negedge clk);
        in_valid = 0;
        chk("dis_pre_count", 300'(queue_count), 300'(2));
        cfg_enable = 0;
        @(negedge clk);
        chk("dis_clear", 300'({out_text_valid, out_text_length}), 300'({1'b1, 5'd0}));
        chk("dis_state", 300'({queue_count, in_ready, showing}), 300'(0));
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            frame_start = c[0];
            n += int'(out_text_valid);
        end
        frame_start = 0;
        chk("dis_no_loads", 300'(n), 300'(0));

        // Duplicate suppression.
        restart();
        cfg_min_frames = 1; cfg_max_frames = 0;
        offer(mk(65), 5'd1);
        offer(mk(65), 5'd1);
        offer(mk(66), 5'd1);
        @(negedge clk);
        in_valid = 0;
`ifdef CAPTION_QUEUE_DEDUP_EN
        chk("dedup_count", 300'(queue_count), 300'(2));
        chk("dedup_dups", 300'(dup_count), 300'(1));
`else
        chk("dedup_count", 300'(queue_count), 300'(3));
        chk("dedup_dups", 300'(dup_count), 300'(0));
`endif

        // Reset while showing: outputs drop, no clear afterwards.
        frame_and_wait(got);
        chk("rst_pre_showing", 300'(showing), 300'(1));
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid_outputs", 300'({out_text_valid, out_text_length, out_text_string, queue_count,
                                      showing, in_ready, dup_count}), 300'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n += int'(out_text_valid);
        end
        chk("rst_no_clear", 300'(n), 300'(0));

        // Random traffic against the model.
        pick[0] = mk(75); pick[1] = mk(76); pick[2] = mk(78);
        restart();
        for (int c = 0; c < 3000; c++) begin
            int k;
            @(negedge clk);
            k = $urandom_range(0, 2);
            in_valid    = ($urandom_range(0, 1) == 1);
            in_text     = pick[k];
            in_length   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'(k * 13);
            frame_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) cfg_enable = 0;
            else if (!cfg_enable && $urandom_range(0, 3) == 0) cfg_enable = 1;
            if ($urandom_range(0, 49) == 0) begin
                cfg_min_frames = 8'($urandom_range(0, 3));
                cfg_max_frames = 8'($urandom_range(0, 4));
            end
        end
        @(negedge clk);
        in_valid = 0; frame_start = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
